// File: rtl/riscv_memory_port.sv
// +--------------------------------------------------------------------------+
// | riscv_memory_port: turns level-held cache requests into one split        |
// | request/response RAM bus transaction, with a timeout and error flag.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module riscv_memory_port #(
   parameter int TIMEOUT   = 255,
   parameter int CNT_WIDTH = 8
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic [31:0] memory_address_i,
   input  logic        memory_read_i,
   input  logic        memory_write_i,
   input  logic [31:0] memory_out_i,
   output logic [31:0] memory_in_o,
   output logic        memory_ready_o,
   output logic [31:0] memory_address_requested_o,
   output logic [31:0] bus_address_o,
   output logic        bus_write_o,
   output logic [31:0] bus_wdata_o,
   output logic        bus_valid_o,
   input  logic        bus_ready_i,
   input  logic        bus_rvalid_i,
   input  logic [31:0] bus_rdata_i,
   output logic        bus_error_o
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam logic [CNT_WIDTH-1:0] c_last_cnt = CNT_WIDTH'(TIMEOUT - 1);

   state_t               state_q;
   logic [31:0]          addr_q;
   logic [31:0]          wdata_q;
   logic                 write_q;
   logic [31:0]          rdata_q;
   logic [31:0]          req_addr_q;
   logic                 ready_q;
   logic                 valid_q;
   logic                 error_q;
   logic [CNT_WIDTH-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         addr_q     <= 32'h0;
         wdata_q    <= 32'h0;
         write_q    <= 1'b0;
         rdata_q    <= 32'h0;
         req_addr_q <= 32'h0;
         ready_q    <= 1'b0;
         valid_q    <= 1'b0;
         error_q    <= 1'b0;
         cnt_q      <= '0;
      end else begin
         ready_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // Write wins when both are requested; the read is simply dropped.
               if (memory_write_i || memory_read_i) begin
                  addr_q  <= memory_address_i & 32'hFFFF_FFFC;
                  wdata_q <= memory_out_i;
                  write_q <= memory_write_i;
                  valid_q <= 1'b1;
                  state_q <= S_REQ;
               end
            end
            S_REQ: begin
               if (bus_ready_i) begin
                  valid_q <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (bus_rvalid_i) begin
                  rdata_q    <= write_q ? wdata_q : bus_rdata_i;
                  req_addr_q <= addr_q;
                  ready_q    <= 1'b1;
                  state_q    <= S_DONE;
               end else if (cnt_q == c_last_cnt) begin
                  rdata_q    <= 32'h0;
                  req_addr_q <= addr_q;
                  error_q    <= 1'b1;
                  ready_q    <= 1'b1;
                  state_q    <= S_DONE;
               end else begin
                  cnt_q <= cnt_q + CNT_WIDTH'(1);
               end
            end
            S_DONE: begin
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign memory_in_o                = rdata_q;
   assign memory_ready_o             = ready_q;
   assign memory_address_requested_o = req_addr_q;
   assign bus_address_o              = addr_q;
   assign bus_write_o                = write_q;
   assign bus_wdata_o                = wdata_q;
   assign bus_valid_o                = valid_q;
   assign bus_error_o                = error_q;

endmodule

`default_nettype wire

// File: tb/tb_riscv_memory_port.sv
// +--------------------------------------------------------------------------+
// | tb_riscv_memory_port: randomized bench with a reactive RAM model.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_riscv_memory_port;

   localparam int TIMEOUT = 8;
   localparam int WINDOW  = 26;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic [31:0] memory_address_i = '0;
   logic        memory_read_i = 1'b0;
   logic        memory_write_i = 1'b0;
   logic [31:0] memory_out_i = '0;
   logic [31:0] memory_in_o;
   logic        memory_ready_o;
   logic [31:0] memory_address_requested_o;
   logic [31:0] bus_address_o;
   logic        bus_write_o;
   logic [31:0] bus_wdata_o;
   logic        bus_valid_o;
   logic        bus_ready_i = 1'b0;
   logic        bus_rvalid_i = 1'b0;
   logic [31:0] bus_rdata_i = '0;
   logic        bus_error_o;

   int n_checks = 0;
   int n_fail   = 0;
   bit err_exp  = 1'b0;

   riscv_memory_port #(.TIMEOUT(TIMEOUT), .CNT_WIDTH(8)) u_dut (
      .clk_i                      (clk_i),
      .rst_ni                     (rst_ni),
      .memory_address_i           (memory_address_i),
      .memory_read_i              (memory_read_i),
      .memory_write_i             (memory_write_i),
      .memory_out_i               (memory_out_i),
      .memory_in_o                (memory_in_o),
      .memory_ready_o             (memory_ready_o),
      .memory_address_requested_o (memory_address_requested_o),
      .bus_address_o              (bus_address_o),
      .bus_write_o                (bus_write_o),
      .bus_wdata_o                (bus_wdata_o),
      .bus_valid_o                (bus_valid_o),
      .bus_ready_i                (bus_ready_i),
      .bus_rvalid_i               (bus_rvalid_i),
      .bus_rdata_i                (bus_rdata_i),
      .bus_error_o                (bus_error_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One cache transaction. Cycle 0 presents the request; the RAM model reacts to
   // bus_valid with 'rdy' stall cycles and answers 'lat' cycles after the handshake.
   task automatic run_txn(input bit do_rd, input bit do_wr, input logic [31:0] addr,
                          input logic [31:0] wdat, input logic [31:0] rdat,
                          input int rdy, input int lat, input int hold);
      bit          to       = (lat >= TIMEOUT);
      logic [31:0] exp_in   = to ? 32'h0 : (do_wr ? wdat : rdat);
      logic [31:0] exp_addr = {addr[31:2], 2'b00};
      int          exp_cyc  = 3 + rdy + (to ? TIMEOUT - 1 : lat);
      int          n_ready  = 0;
      int          rdy_cyc  = -1;
      int          n_valid  = 0;
      int          hs       = -1;
      bit          seen     = 1'b0;
      bit          req;
      logic [31:0] got_in   = '0;
      logic [31:0] got_addr = '0;
      for (int k = 0; k < WINDOW; k++) begin
         @(negedge clk_i);
         if (memory_ready_o) begin
            n_ready++;
            rdy_cyc  = k;
            got_in   = memory_in_o;
            got_addr = memory_address_requested_o;
            seen     = 1'b1;
         end
         if (bus_valid_o) begin
            n_valid++;
            check("bus_address", bus_address_o, exp_addr);
            check("bus_write", 32'(bus_write_o), 32'(do_wr));
            if (do_wr) check("bus_wdata", bus_wdata_o, wdat);
         end
         req              = (k < hold) && !seen;
         memory_read_i    = req && do_rd;
         memory_write_i   = req && do_wr;
         memory_address_i = (k == 0) ? addr : $urandom;
         memory_out_i     = (k == 0) ? wdat : $urandom;
         bus_ready_i      = bus_valid_o && (n_valid > rdy);
         if (bus_ready_i && hs < 0) hs = k;
         if (hs >= 0 && k == hs + 1 + lat) begin
            bus_rvalid_i = 1'b1;
            bus_rdata_i  = rdat;
         end else begin
            bus_rvalid_i = bus_valid_o && ($urandom_range(0, 1) == 1);
            bus_rdata_i  = $urandom;
         end
      end
      if (to) err_exp = 1'b1;
      check("ready_pulses", 32'(n_ready), 32'd1);
      check("ready_cycle", 32'(rdy_cyc), 32'(exp_cyc));
      check("memory_in", got_in, exp_in);
      check("requested_addr", got_addr, exp_addr);
      check("valid_cycles", 32'(n_valid), 32'(rdy + 1));
      check("bus_error", 32'(bus_error_o), 32'(err_exp));
      check("memory_in_hold", memory_in_o, exp_in);
   endtask

   task automatic reset_mid_wait();
      int n_ready = 0;
      int n_valid = 0;
      for (int k = 0; k < 14; k++) begin
         @(negedge clk_i);
         if (k >= 4) begin
            if (memory_ready_o) n_ready++;
            if (bus_valid_o) n_valid++;
         end
         if (k == 4) begin
            check("rst_bus_valid", 32'(bus_valid_o), 32'd0);
            check("rst_bus_error", 32'(bus_error_o), 32'd0);
            check("rst_memory_in", memory_in_o, 32'h0);
         end
         memory_read_i    = (k == 0);
         memory_write_i   = 1'b0;
         memory_address_i = 32'h0000_0800;
         bus_ready_i      = bus_valid_o;
         rst_ni           = (k != 3);
         bus_rvalid_i     = (k == 5);
         bus_rdata_i      = 32'hDEAD_BEEF;
      end
      err_exp = 1'b0;
      check("rst_late_ready", 32'(n_ready), 32'd0);
      check("rst_no_reissue", 32'(n_valid), 32'd0);
      check("rst_error_clear", 32'(bus_error_o), 32'd0);
   endtask

   initial begin
      int kind;
      repeat (2) @(negedge clk_i);
      check("reset_ready", 32'(memory_ready_o), 32'd0);
      check("reset_valid", 32'(bus_valid_o), 32'd0);
      check("reset_error", 32'(bus_error_o), 32'd0);
      check("reset_memory_in", memory_in_o, 32'h0);
      check("reset_requested", memory_address_requested_o, 32'h0);
      check("reset_bus_address", bus_address_o, 32'h0);
      check("reset_bus_wdata", bus_wdata_o, 32'h0);
      rst_ni = 1'b1;

      run_txn(1'b1, 1'b0, 32'h0000_1004, 32'h0, 32'hCAFE_F00D, 0, 0, 3);
      run_txn(1'b1, 1'b0, 32'h0000_1100, 32'h0, 32'h0BAD_CAFE, 0, 3, 10);
      run_txn(1'b0, 1'b1, 32'h0000_2003, 32'h1234_5678, 32'h5555_AAAA, 3, 1, 12);
      run_txn(1'b1, 1'b0, 32'h0000_3000, 32'h0, 32'h7777_7777, 1, 12, 4);
      run_txn(1'b1, 1'b1, 32'h0000_0040, 32'hA5A5_0040, 32'h0F0F_0F0F, 0, 2, 14);

      for (int i = 0; i < 40; i++) begin
         kind = $urandom_range(0, 2);
         run_txn(kind != 1, kind != 0, $urandom, $urandom, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 12), $urandom_range(1, 14));
      end

      reset_mid_wait();
      for (int i = 0; i < 4; i++) begin
         run_txn(1'b1, 1'b0, $urandom, $urandom, $urandom,
                 $urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(1, 14));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
